// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared constants and round/narrow helper for the FIR
//               decimator. Honours FIR_DECIM_SAT_EN (saturate instead of wrap).
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int                  c_PHASE_W       = 7;
    localparam logic [c_PHASE_W-1:0] c_PHASE_LAST   = 7'h7F;
    localparam int                  c_DEF_IN_WIDTH  = 20;
    localparam int                  c_DEF_OUT_WIDTH = 16;

    // Round-half-up by in_w-out_w bits; result is sign-extended in 32 bits,
    // callers keep the low out_w bits (wrap) unless saturation is compiled in.
    function automatic logic signed [31:0] round_narrow(
        input logic signed [31:0] v,
        input int                 in_w,
        input int                 out_w
    );
        int                 s;
        logic signed [31:0] acc;
`ifdef FIR_DECIM_SAT_EN
        logic signed [31:0] hi;
        logic signed [31:0] lo;
`endif
        s   = in_w - out_w;
        acc = (v + (32'sd1 <<< (s - 1))) >>> s;
`ifdef FIR_DECIM_SAT_EN
        hi  = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        lo  = -(32'sd1 <<< (out_w - 1));
        if (acc > hi) acc = hi;
        if (acc < lo) acc = lo;
`endif
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_decimator_if.sv
`default_nettype none
// ============================================================================
// Module      : fir_decimator_if
// Description : Filter-side input and valid/ready output bundle of the
//               decimator; master = environment, slave = decimator.
// Revision    : 1.0 - initial release
// ============================================================================
interface fir_decimator_if
    import fir_pkg::*;
#(
    parameter int IN_WIDTH  = c_DEF_IN_WIDTH,
    parameter int OUT_WIDTH = c_DEF_OUT_WIDTH
);
    logic                        fir_ready;
    logic signed [IN_WIDTH-1:0]  in_sig;
    logic signed [OUT_WIDTH-1:0] out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic                        ovf;
    logic                        clr_ovf;

    modport master (
        output fir_ready, in_sig, out_ready, clr_ovf,
        input  out_data, out_valid, ovf
    );

    modport slave (
        input  fir_ready, in_sig, out_ready, clr_ovf,
        output out_data, out_valid, ovf
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO, register-array storage, head read from a
//               register; accepts a push while full only with a same-cycle pop.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_push,
    input  wire logic             i_pop,
    input  wire logic [WIDTH-1:0] i_din,
    output logic      [WIDTH-1:0] o_dout,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam int               c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]    c_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr;
    logic [c_AW-1:0]  r_rd;
    logic [c_AW:0]    r_cnt;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == c_FULL);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_dout  = r_mem[r_rd];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_din;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/fir_decimator.sv
`default_nettype none
// ============================================================================
// Module      : fir_decimator
// Description : Tracks the 128-tap filter's ready schedule, keeps every
//               DECIM-th result, rounds it to OUT_WIDTH and queues it.
//               FIR_DECIM_SAT_EN: saturate on narrowing instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_decimator
    import fir_pkg::*;
#(
    parameter int IN_WIDTH   = c_DEF_IN_WIDTH,
    parameter int OUT_WIDTH  = c_DEF_OUT_WIDTH,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input wire logic       clk,
    input wire logic       rst_n,
    fir_decimator_if.slave bus
);
    localparam logic [7:0] c_DCNT_MAX = 8'(DECIM - 1);

    logic [c_PHASE_W-1:0] r_phase;
    logic                 r_cap_pend;
    logic [7:0]           r_dcnt;
    logic [OUT_WIDTH-1:0] r_rnd;
    logic                 r_push;
    logic                 r_ovf;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_drop;
    logic [OUT_WIDTH-1:0] w_dout;
    logic signed [31:0]   w_in_ext;

    assign w_in_ext = {{(32 - IN_WIDTH){bus.in_sig[IN_WIDTH-1]}}, bus.in_sig};
    assign w_pop    = !w_empty && bus.out_ready;
    // A full FIFO still takes the push if the head leaves in the same cycle.
    assign w_drop   = r_push && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase    <= c_PHASE_LAST;
            r_cap_pend <= 1'b0;
            r_dcnt     <= 8'd0;
            r_rnd      <= '0;
            r_push     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (bus.fir_ready) r_phase <= r_phase + 1'b1;
            // Filter reloads filtred_sig on the ready edge that wraps its read index.
            r_cap_pend <= bus.fir_ready && (r_phase == c_PHASE_LAST);
            r_push     <= r_cap_pend && (r_dcnt == 8'd0);
            if (r_cap_pend) begin
                r_rnd  <= OUT_WIDTH'(round_narrow(w_in_ext, IN_WIDTH, OUT_WIDTH));
                r_dcnt <= (r_dcnt == c_DCNT_MAX) ? 8'd0 : r_dcnt + 8'd1;
            end
            if (w_drop)           r_ovf <= 1'b1;
            else if (bus.clr_ovf) r_ovf <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_push),
        .i_pop   (w_pop),
        .i_din   (r_rnd),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_dout;
    assign bus.ovf       = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_fir_decimator.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_decimator
// Description : Self-checking bench; DECIM=1 and DECIM=4 instances share the
//               filter-side stimulus and are compared against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_decimator;
    localparam int IW    = 20;
    localparam int OW    = 16;
    localparam int DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 fir_ready;
    logic                 clr_ovf;
    logic signed [IW-1:0] in_sig;
    logic                 ordy      [0:1];
    logic                 obs_valid [0:1];
    logic                 obs_ovf   [0:1];
    logic [OW-1:0]        obs_data  [0:1];

    fir_decimator_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus1 ();
    fir_decimator_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus4 ();

    assign bus1.fir_ready = fir_ready;
    assign bus1.in_sig    = in_sig;
    assign bus1.clr_ovf   = clr_ovf;
    assign bus1.out_ready = ordy[0];
    assign bus4.fir_ready = fir_ready;
    assign bus4.in_sig    = in_sig;
    assign bus4.clr_ovf   = clr_ovf;
    assign bus4.out_ready = ordy[1];
    assign obs_valid[0]   = bus1.out_valid;
    assign obs_valid[1]   = bus4.out_valid;
    assign obs_ovf[0]     = bus1.ovf;
    assign obs_ovf[1]     = bus4.ovf;
    assign obs_data[0]    = bus1.out_data;
    assign obs_data[1]    = bus4.out_data;

    fir_decimator #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DECIM(1), .FIFO_DEPTH(DEPTH))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    fir_decimator #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DECIM(4), .FIFO_DEPTH(DEPTH))
        u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: counts ready edges since reset and keeps expected outputs in queues.
    int            nedge;
    int            ncap;
    bit            cap_next;
    bit            cap_seen;
    bit            push_next [0:1];
    logic [OW-1:0] push_val  [0:1];
    bit            ovf_m     [0:1];
    logic [OW-1:0] mq        [0:1][$];
    int            dec       [0:1] = '{1, 4};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [OW-1:0] ref_round(input logic signed [IW-1:0] x);
        int v;
        int q;
        v = x;
        v = v + 8;
        if (v >= 0) q = v / 16;
        else        q = -((-v + 15) / 16);
`ifdef FIR_DECIM_SAT_EN
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
`endif
        return q[OW-1:0];
    endfunction

    task automatic model_reset();
        nedge    = 0;
        ncap     = 0;
        cap_next = 0;
        cap_seen = 0;
        for (int k = 0; k < 2; k++) begin
            push_next[k] = 0;
            push_val[k]  = '0;
            ovf_m[k]     = 0;
            mq[k].delete();
        end
    endtask

    task automatic check_outputs(input string s);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_valid%0d", s, k), 32'(obs_valid[k]), 32'(mq[k].size() > 0));
            chk($sformatf("%s_ovf%0d", s, k), 32'(obs_ovf[k]), 32'(ovf_m[k]));
            if (mq[k].size() > 0)
                chk($sformatf("%s_data%0d", s, k), 32'(obs_data[k]), 32'(mq[k][0]));
        end
    endtask

    task automatic tick();
        bit                   pop [0:1];
        bit                   fr;
        bit                   clr;
        logic signed [IW-1:0] x;
        for (int k = 0; k < 2; k++) pop[k] = (mq[k].size() > 0) && ordy[k];
        fr  = fir_ready;
        clr = clr_ovf;
        x   = in_sig;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
            #1;
            check_outputs("in_reset");
            return;
        end
        for (int k = 0; k < 2; k++) begin
            bit drop;
            drop = push_next[k] && (mq[k].size() == DEPTH) && !pop[k];
            if (pop[k]) void'(mq[k].pop_front());
            if (push_next[k] && !drop) mq[k].push_back(push_val[k]);
            if (drop)     ovf_m[k] = 1;
            else if (clr) ovf_m[k] = 0;
            push_next[k] = cap_next && (ncap % dec[k] == 0);
            push_val[k]  = ref_round(x);
        end
        if (cap_next) begin
            ncap++;
            cap_seen = 1;
        end
        cap_next = fr && (nedge % 128 == 0);
        if (fr) nedge++;
        #1;
        check_outputs("cyc");
    endtask

    // mode 0: keep out_ready, 1: DUT1 pops only on its push cycle, 2: random out_ready
    task automatic drive_ready(input int mode);
        if (mode == 1) begin
            ordy[0] = push_next[0];
            ordy[1] = 1'b0;
        end else if (mode == 2) begin
            ordy[0] = 1'($urandom_range(0, 1));
            ordy[1] = 1'($urandom_range(0, 1));
        end
    endtask

    // Presents v, waits for the filter update to be captured, returns just after the FIFO write.
    task automatic next_update(input logic signed [IW-1:0] v, input int mode);
        in_sig   = v;
        cap_seen = 0;
        for (int n = 0; n < 1000 && !cap_seen; n++) begin
            fir_ready = ($urandom_range(0, 3) != 0);
            drive_ready(mode);
            tick();
        end
        if (!cap_seen) chk("update_timeout", 32'd0, 32'd1);
        fir_ready = ($urandom_range(0, 3) != 0);
        drive_ready(mode);
        tick();
    endtask

    initial begin
        logic signed [IW-1:0] first;
        logic signed [IW-1:0] v;
        logic [OW-1:0]        big_exp;

        rst_n     = 1'b0;
        fir_ready = 1'b0;
        clr_ovf   = 1'b0;
        in_sig    = '0;
        ordy[0]   = 1'b0;
        ordy[1]   = 1'b0;
        model_reset();
        #23;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset_valid%0d", k), 32'(obs_valid[k]), 32'd0);
            chk($sformatf("reset_data%0d", k), 32'(obs_data[k]), 32'd0);
            chk($sformatf("reset_ovf%0d", k), 32'(obs_ovf[k]), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First update edge right after reset, ready held high.
        fir_ready = 1'b1;
        in_sig    = 20'sd24;
        ordy[0]   = 1'b1;
        ordy[1]   = 1'b1;
        tick();
        tick();
        chk("first_valid_e1", 32'(obs_valid[0]), 32'd0);
        tick();
        chk("first_valid_e2", 32'(obs_valid[0]), 32'd1);
        chk("first_data", 32'(obs_data[0]), 32'h0002);

        next_update(-20'sd24, 0);
        chk("neg24_data", 32'(obs_data[0]), 32'hFFFF);
`ifdef FIR_DECIM_SAT_EN
        big_exp = 16'h7FFF;
`else
        big_exp = 16'h8000;
`endif
        next_update(20'sh7FFF8, 0);
        chk("big_data", 32'(obs_data[0]), 32'(big_exp));

        for (int j = 1; j <= 9; j++) next_update(IW'(16 * j), 0);
        for (int j = 0; j < 4; j++) next_update(IW'($urandom), 2);

        // Stall the consumer: four held, the fifth dropped.
        ordy[0] = 1'b1;
        ordy[1] = 1'b1;
        repeat (8) tick();
        ordy[0] = 1'b0;
        ordy[1] = 1'b0;
        first   = IW'($urandom);
        next_update(first, 0);
        for (int j = 0; j < 3; j++) next_update(IW'($urandom), 0);
        chk("full_valid", 32'(obs_valid[0]), 32'd1);
        chk("full_ovf", 32'(obs_ovf[0]), 32'd0);
        chk("full_head", 32'(obs_data[0]), 32'(ref_round(first)));
        next_update(IW'($urandom), 0);
        chk("drop_ovf", 32'(obs_ovf[0]), 32'd1);
        chk("drop_head", 32'(obs_data[0]), 32'(ref_round(first)));

        // Drop coinciding with clear keeps the flag; clear alone then resets it.
        clr_ovf = 1'b1;
        next_update(IW'($urandom), 0);
        chk("drop_clr_ovf", 32'(obs_ovf[0]), 32'd1);
        tick();
        chk("clr_ovf", 32'(obs_ovf[0]), 32'd0);
        clr_ovf = 1'b0;

        // Full FIFO with a pop on the push cycle: no drop.
        next_update(IW'($urandom), 1);
        chk("pushpop_ovf", 32'(obs_ovf[0]), 32'd0);
        chk("pushpop_valid", 32'(obs_valid[0]), 32'd1);
        ordy[0] = 1'b1;
        ordy[1] = 1'b1;
        repeat (8) tick();

        for (int j = 0; j < 4; j++) next_update(IW'($urandom), 2);

        // Asynchronous reset mid-frame.
        ordy[0] = 1'b0;
        ordy[1] = 1'b0;
        next_update(IW'($urandom), 0);
        fir_ready = 1'b1;
        for (int n = 0; n < 300 && (nedge % 128 != 61); n++) tick();
        chk("pre_reset_valid", 32'(obs_valid[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("async_valid%0d", k), 32'(obs_valid[k]), 32'd0);
            chk($sformatf("async_data%0d", k), 32'(obs_data[k]), 32'd0);
            chk($sformatf("async_ovf%0d", k), 32'(obs_ovf[k]), 32'd0);
        end
        tick();
        tick();
        rst_n  = 1'b1;
        v      = IW'($urandom);
        in_sig = v;
        tick();
        tick();
        chk("rerun_valid_e1", 32'(obs_valid[0]), 32'd0);
        tick();
        chk("rerun_valid_e2", 32'(obs_valid[0]), 32'd1);
        chk("rerun_data", 32'(obs_data[0]), 32'(ref_round(v)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
